// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single SDRAM controller slave.
// Serves one 16-bit transaction at a time. A stuck read is completed with 16'hDEAD after RD_TIMEOUT cycles.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [15:0]       a_writedata,
    output logic              a_waitrequest,
    output logic [15:0]       a_readdata,
    output logic              a_readdatavalid,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [15:0]       b_writedata,
    output logic              b_waitrequest,
    output logic [15:0]       b_readdata,
    output logic              b_readdatavalid,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [15:0]       m_writedata,
    input  logic              m_waitrequest,
    input  logic [15:0]       m_readdata,
    input  logic              m_readdatavalid
);
    localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_address_q, m_address_d;
    logic [15:0]       m_writedata_q, m_writedata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       a_readdata_q, a_readdata_d;
    logic [15:0]       b_readdata_q, b_readdata_d;
    logic              a_rdv_q, a_rdv_d;
    logic              b_rdv_q, b_rdv_d;

    logic              a_pend_s, b_pend_s, sel_b_s, wr_s;
    logic              rd_done_s;
    logic [15:0]       rd_data_s;
    logic              accept_s;

    // Accept is visible to the requester in the same cycle the slave drops its stall.
    assign accept_s        = (state_q == ST_ISSUE) && !m_waitrequest;
    assign a_waitrequest   = !(accept_s && !gnt_q);
    assign b_waitrequest   = !(accept_s && gnt_q);
    assign m_read          = m_read_q;
    assign m_write         = m_write_q;
    assign m_address       = m_address_q;
    assign m_writedata     = m_writedata_q;
    assign a_readdata      = a_readdata_q;
    assign b_readdata      = b_readdata_q;
    assign a_readdatavalid = a_rdv_q;
    assign b_readdatavalid = b_rdv_q;

    // Next-state logic: arbitration, command hold and read completion.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        m_read_d      = m_read_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        cnt_d         = cnt_q;
        a_readdata_d  = a_readdata_q;
        b_readdata_d  = b_readdata_q;
        a_rdv_d       = 1'b0;
        b_rdv_d       = 1'b0;
        rd_done_s     = 1'b0;
        rd_data_s     = 16'h0000;
        a_pend_s      = a_read | a_write;
        b_pend_s      = b_read | b_write;
        sel_b_s       = (a_pend_s && b_pend_s) ? ~last_grant_q : b_pend_s;
        // A simultaneous read+write from one requester is served as a write.
        wr_s          = sel_b_s ? b_write : a_write;

        case (state_q)
            ST_IDLE: begin
                if (a_pend_s || b_pend_s) begin
                    gnt_d         = sel_b_s;
                    m_write_d     = wr_s;
                    m_read_d      = ~wr_s;
                    m_address_d   = sel_b_s ? b_address : a_address;
                    m_writedata_d = sel_b_s ? b_writedata : a_writedata;
                    state_d       = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!m_waitrequest) begin
                    m_read_d     = 1'b0;
                    m_write_d    = 1'b0;
                    last_grant_d = gnt_q;
                    cnt_d        = {CNT_W{1'b0}};
                    state_d      = m_write_q ? ST_IDLE : ST_RDWAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RDWAIT: begin
                if (m_readdatavalid) begin
                    rd_done_s = 1'b1;
                    rd_data_s = m_readdata;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_done_s = 1'b1;
                    rd_data_s = 16'hDEAD;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
        endcase

        if (rd_done_s && gnt_q) begin
            b_readdata_d = rd_data_s;
            b_rdv_d      = 1'b1;
        end else if (rd_done_s) begin
            a_readdata_d = rd_data_s;
            a_rdv_d      = 1'b1;
        end else begin
            a_rdv_d = 1'b0;
            b_rdv_d = 1'b0;
        end
    end

    // State and registered outputs; last_grant resets to B so A wins the first tie.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= {ADDR_W{1'b0}};
            m_writedata_q <= 16'h0000;
            cnt_q         <= {CNT_W{1'b0}};
            a_readdata_q  <= 16'h0000;
            b_readdata_q  <= 16'h0000;
            a_rdv_q       <= 1'b0;
            b_rdv_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_grant_q  <= last_grant_d;
            m_read_q      <= m_read_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            cnt_q         <= cnt_d;
            a_readdata_q  <= a_readdata_d;
            b_readdata_q  <= b_readdata_d;
            a_rdv_q       <= a_rdv_d;
            b_rdv_q       <= b_rdv_d;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter. Directed and random transactions are checked
// against a transaction-level model of round-robin order, command contents and read completion timing.
module tb_sdram_port_arbiter;
    localparam int AW = 25;
    localparam int TO = 255;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic          a_read, a_write, b_read, b_write;
    logic [AW-1:0] a_address, b_address, m_address;
    logic [15:0]   a_writedata, b_writedata, m_writedata;
    logic          a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
    logic [15:0]   a_readdata, b_readdata, m_readdata;
    logic          m_read, m_write, m_waitrequest, m_readdatavalid;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level model
    bit            last_g;
    bit            pend [2];
    bit            pwr  [2];
    logic [AW-1:0] paddr [2];
    logic [15:0]   pdata [2];
    logic [15:0]   exp_rd [2];

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(.ADDR_W(AW), .RD_TIMEOUT(TO)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_writedata(a_writedata),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_writedata(b_writedata),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    function automatic logic wait_of(input int p);
        return (p != 0) ? b_waitrequest : a_waitrequest;
    endfunction

    function automatic logic rdv_of(input int p);
        return (p != 0) ? b_readdatavalid : a_readdatavalid;
    endfunction

    function automatic logic [15:0] rd_of(input int p);
        return (p != 0) ? b_readdata : a_readdata;
    endfunction

    task automatic drive_port(input int p, input bit rd, input bit wr,
                              input logic [AW-1:0] ad, input logic [15:0] wd);
        if (p == 0) begin
            a_read = rd; a_write = wr; a_address = ad; a_writedata = wd;
        end else begin
            b_read = rd; b_write = wr; b_address = ad; b_writedata = wd;
        end
        pend[p]  = rd | wr;
        pwr[p]   = wr;
        paddr[p] = ad;
        pdata[p] = wd;
    endtask

    // Runs one transaction from an IDLE-cycle negedge; lat=0 means the slave never returns data.
    task automatic do_txn(input int stall, input int lat, input logic [15:0] rdata, output int winner);
        int w, l, ev;
        bit wr;
        logic [15:0] edata;
        w  = (pend[0] && pend[1]) ? (last_g ? 0 : 1) : (pend[0] ? 0 : 1);
        l  = 1 - w;
        wr = pwr[w];
        winner = w;
        @(negedge clk_clk);
        n_checks++;
        if (m_write !== wr || m_read !== !wr) begin
            n_fail++;
            $display("FAIL cmd_type: port %0d got m_read=%0b m_write=%0b, want write=%0b", w, m_read, m_write, wr);
        end
        n_checks++;
        if (m_address !== paddr[w] || (wr && m_writedata !== pdata[w])) begin
            n_fail++;
            $display("FAIL cmd_payload: got addr=%h data=%h, want addr=%h data=%h", m_address, m_writedata, paddr[w], pdata[w]);
        end
        n_checks++;
        if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse_width: got a=%0b b=%0b, want 0 0", a_readdatavalid, b_readdatavalid);
        end
        for (int s = 0; s < stall; s++) begin
            n_checks++;
            if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1 || m_write !== wr || m_read !== !wr
                || m_address !== paddr[w]) begin
                n_fail++;
                $display("FAIL stall_hold: got waits=%0b%0b rd=%0b wr=%0b addr=%h, want waits=11 cmd held", a_waitrequest, b_waitrequest, m_read, m_write, m_address);
            end
            m_readdatavalid = 1'($urandom_range(0, 1));
            m_readdata      = 16'($urandom);
            @(negedge clk_clk);
        end
        m_readdatavalid = 1'b0;
        m_waitrequest   = 1'b0;
        #1;
        n_checks++;
        if (wait_of(w) !== 1'b0 || wait_of(l) !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: winner %0d wait=%0b other wait=%0b, want 0 and 1", w, wait_of(w), wait_of(l));
        end
        @(posedge clk_clk);
        #1;
        m_waitrequest = 1'b1;
        drive_port(w, 1'b0, 1'b0, paddr[w], pdata[w]);
        last_g = (w != 0);
        if (wr) begin
            @(negedge clk_clk);
            n_checks++;
            if (m_write !== 1'b0 || m_read !== 1'b0 || a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) begin
                n_fail++;
                $display("FAIL write_done: got rd=%0b wr=%0b waits=%0b%0b, want 0 0 11", m_read, m_write, a_waitrequest, b_waitrequest);
            end
            return;
        end
        if (lat >= 1 && lat <= TO) begin
            ev = lat + 1;
            edata = rdata;
        end else begin
            ev = TO + 1;
            edata = 16'hDEAD;
        end
        for (int k = 1; k <= ev; k++) begin
            @(negedge clk_clk);
            m_readdatavalid = 1'b0;
            if (k == ev) begin
                n_checks++;
                if (rdv_of(w) !== 1'b1 || rd_of(w) !== edata || rdv_of(l) !== 1'b0 || rd_of(l) !== exp_rd[l]) begin
                    n_fail++;
                    $display("FAIL read_complete: port %0d valid=%0b data=%h other valid=%0b data=%h, want 1 %h 0 %h", w, rdv_of(w), rd_of(w), rdv_of(l), rd_of(l), edata, exp_rd[l]);
                end
                exp_rd[w] = edata;
            end else begin
                n_checks++;
                if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0 || m_read !== 1'b0
                    || a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rdwait_quiet: cycle %0d valids=%0b%0b m_read=%0b waits=%0b%0b, want 00 0 11", k, a_readdatavalid, b_readdatavalid, m_read, a_waitrequest, b_waitrequest);
                end
            end
            if (k == lat) begin
                m_readdatavalid = 1'b1;
                m_readdata      = rdata;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (m_read !== 1'b0 || m_write !== 1'b0 || m_address !== '0 || m_writedata !== 16'h0000
            || a_readdata !== 16'h0000 || b_readdata !== 16'h0000 || a_readdatavalid !== 1'b0
            || b_readdatavalid !== 1'b0 || a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got rd=%0b wr=%0b addr=%h wd=%h ard=%h brd=%h vals=%0b%0b waits=%0b%0b, want all zero, waits 11", tag, m_read, m_write, m_address, m_writedata, a_readdata, b_readdata, a_readdatavalid, b_readdatavalid, a_waitrequest, b_waitrequest);
        end
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, 16'h0000);
        drive_port(1, 1'b0, 1'b0, '0, 16'h0000);
        m_waitrequest = 1'b1; m_readdatavalid = 1'b0; m_readdata = 16'h0000;
        last_g = 1'b1; exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
        #1;
        check_reset_values("reset_async");
        repeat (3) @(negedge clk_clk);
        check_reset_values("reset_hold");
        reset_reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int w;
        drive_port(0, 1'b1, 1'b0, 25'h0000100, 16'h0000);
        drive_port(1, 1'b1, 1'b0, 25'h0000200, 16'h0000);
        do_txn(0, 2, 16'h1111, w);
        n_checks++;
        if (w != 0) begin n_fail++; $display("FAIL rr_first: got port %0d, want 0", w); end
        drive_port(0, 1'b1, 1'b0, 25'h0000300, 16'h0000);
        do_txn(1, 3, 16'h2222, w);
        n_checks++;
        if (w != 1) begin n_fail++; $display("FAIL rr_second: got port %0d, want 1", w); end
        do_txn(0, 1, 16'h3333, w);
        n_checks++;
        if (w != 0) begin n_fail++; $display("FAIL rr_third: got port %0d, want 0", w); end
    endtask

    task automatic test_write_single();
        int w;
        drive_port(0, 1'b0, 1'b1, 25'h0000010, 16'h1234);
        do_txn(0, 0, 16'h0000, w);
    endtask

    task automatic test_read_stall();
        int w;
        drive_port(1, 1'b1, 1'b0, 25'h0ABCDEF, 16'h0000);
        do_txn(3, 4, 16'hBEEF, w);
        n_checks++;
        if (b_readdata !== 16'hBEEF || a_readdata !== exp_rd[0]) begin
            n_fail++;
            $display("FAIL read_stall_data: got b=%h a=%h, want b=BEEF a=%h", b_readdata, a_readdata, exp_rd[0]);
        end
    endtask

    task automatic test_rw_both();
        int w;
        drive_port(0, 1'b1, 1'b1, 25'h1555555, 16'hA5A5);
        do_txn(1, 0, 16'h0000, w);
    endtask

    task automatic test_back_to_back();
        int w;
        drive_port(0, 1'b0, 1'b1, 25'h0000020, 16'hCAFE);
        drive_port(1, 1'b0, 1'b1, 25'h0000040, 16'hF00D);
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 0, 16'h0000, w);
            drive_port(w, 1'b0, 1'b1, AW'(32'h80 + 32'(i)), 16'(32'h100 + 32'(i)));
        end
        do_txn(0, 0, 16'h0000, w);
        do_txn(0, 0, 16'h0000, w);
    endtask

    task automatic test_timeout();
        int w;
        drive_port(0, 1'b1, 1'b0, 25'h0000777, 16'h0000);
        do_txn(0, 0, 16'h0000, w);
        n_checks++;
        if (a_readdata !== 16'hDEAD) begin
            n_fail++;
            $display("FAIL timeout_data: got %h, want DEAD", a_readdata);
        end
    endtask

    task automatic test_random();
        int w, r;
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 2);
                    drive_port(p, r != 1, r != 0, AW'($urandom), 16'($urandom));
                end
            end
            if (!pend[0] && !pend[1]) begin
                drive_port(0, 1'b0, 1'b1, AW'($urandom), 16'($urandom));
            end
            do_txn($urandom_range(0, 3), $urandom_range(1, 6), 16'($urandom), w);
        end
        while (pend[0] || pend[1]) do_txn(0, 1, 16'($urandom), w);
    endtask

    task automatic test_reset_abandon();
        drive_port(0, 1'b1, 1'b0, 25'h0000999, 16'h0000);
        @(negedge clk_clk);
        m_waitrequest = 1'b0;
        @(posedge clk_clk);
        #1;
        m_waitrequest = 1'b1;
        drive_port(0, 1'b0, 1'b0, '0, 16'h0000);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b0;
        last_g = 1'b1; exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
        #1;
        check_reset_values("abandon_reset");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        m_readdatavalid = 1'b1;
        m_readdata = 16'h5555;
        @(negedge clk_clk);
        m_readdatavalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_reset_values("abandon_late_rdv");
            @(negedge clk_clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_write_single();
        test_read_stall();
        test_rw_both();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_abandon();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
